// File: rtl/rv32im_fetch_ctrl.sv
// rv32im_fetch_ctrl: instruction-fetch sequencer for the rv32im core.
// Owns the program counter and drives a synchronous instruction ROM, whose read
// data arrives one cycle after the enable. Fetched words are handed to decode
// through valid/ready. A one-entry skid buffer absorbs decode backpressure.
// Branch/jump redirects flush any read in flight and any skid entry.
//
// Optional feature macro: FETCH_MISALIGN_TRAP_EN
//   defined   : a redirect whose target has bits [1:0] != 0 parks the fetcher
//               in S_TRAP and raises a sticky misalign_o. Only an aligned
//               redirect or a reset leaves S_TRAP.
//   undefined : the low two bits of the redirect target are forced to zero.
//               misalign_o is tied low and S_TRAP does not exist.
//
// Handshake (decode side): instr_o/instr_pc_o are stable and meaningful while
// instr_valid_o is high. A transfer happens on a rising edge where
// instr_valid_o && instr_ready_i. The fetcher never withdraws or changes a
// presented instruction before it is accepted. The one exception is a
// redirect: it drops the instruction and forces instr_valid_o low that cycle,
// so nothing transfers in the redirect cycle even if ready is high.
//
// state_dbg_o exposes the FSM state so external checkers can observe it.

module rv32im_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        rom_en_o,
    output logic [31:0] rom_addr_o,
    input  logic [31:0] rom_data_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        misalign_o,
    output logic [2:0]  state_dbg_o
);

`ifdef FETCH_MISALIGN_TRAP_EN
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_HOLD  = 3'd2,
        S_REDIR = 3'd3,
        S_TRAP  = 3'd4
    } state_e;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_HOLD  = 3'd2,
        S_REDIR = 3'd3
    } state_e;
`endif

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        infl_v_q, infl_v_d;
    logic [31:0] infl_pc_q, infl_pc_d;
    logic        skid_v_q, skid_v_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic        misalign_q, misalign_d;

    // Redirect target as it is applied to the PC.
    logic [31:0] redir_pc;
    logic        redir_misaligned;
    // An in-flight word that decode refuses this cycle.
    logic        stall_infl;
    // A ROM read is issued this cycle.
    logic        issue;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign redir_pc         = redirect_pc_i;
    assign redir_misaligned = |redirect_pc_i[1:0];
`else
    // The low bits are discarded: the target is rounded down to a word.
    logic unused_redir_lo;
    assign unused_redir_lo  = ^redirect_pc_i[1:0];
    assign redir_pc         = {redirect_pc_i[31:2], 2'b00};
    assign redir_misaligned = 1'b0;
`endif

    assign stall_infl = infl_v_q && !instr_ready_i;

    // State register: every flop in the block, cleared asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            infl_v_q     <= 1'b0;
            infl_pc_q    <= 32'h0;
            skid_v_q     <= 1'b0;
            skid_instr_q <= 32'h0;
            skid_pc_q    <= 32'h0;
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            infl_v_q     <= infl_v_d;
            infl_pc_q    <= infl_pc_d;
            skid_v_q     <= skid_v_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            misalign_q   <= misalign_d;
        end
    end

    // Next-state logic: a redirect overrides every other transition.
    always_comb begin
        state_d = state_q;
        if (redirect_i) begin
`ifdef FETCH_MISALIGN_TRAP_EN
            state_d = redir_misaligned ? S_TRAP : S_REDIR;
`else
            state_d = S_REDIR;
`endif
        end else begin
            case (state_q)
                S_IDLE:  state_d = S_RUN;
                S_RUN:   if (stall_infl) state_d = S_HOLD;
                S_HOLD:  if (instr_ready_i) state_d = S_RUN;
                S_REDIR: state_d = S_RUN;
`ifdef FETCH_MISALIGN_TRAP_EN
                S_TRAP:  state_d = S_TRAP;
`endif
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output and datapath logic: issue decision, skid capture/release, flush.
    always_comb begin
        issue        = 1'b0;
        pc_d         = pc_q;
        infl_v_d     = 1'b0;
        infl_pc_d    = infl_pc_q;
        skid_v_d     = skid_v_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        misalign_d   = misalign_q;

        if (redirect_i) begin
            // Flush: drop the read in flight and the skid entry, retarget.
            skid_v_d   = 1'b0;
            pc_d       = redir_pc;
            misalign_d = redir_misaligned;
        end else begin
            case (state_q)
                S_RUN: begin
                    // Issue only when the word now in flight can leave this
                    // cycle. A refused word moves to the skid buffer instead.
                    issue = !skid_v_q && !stall_infl;
                    if (stall_infl) begin
                        skid_v_d     = 1'b1;
                        skid_instr_d = rom_data_i;
                        skid_pc_d    = infl_pc_q;
                    end
                end
                S_HOLD: begin
                    if (instr_ready_i) skid_v_d = 1'b0;
                end
                S_REDIR: issue = 1'b1;
                default: issue = 1'b0;
            endcase

            if (issue) begin
                infl_v_d  = 1'b1;
                infl_pc_d = pc_q;
                pc_d      = pc_q + 32'd4;
            end
        end

        rom_en_o   = issue;
        rom_addr_o = pc_q;

        // The skid entry is older than anything in flight, so it wins the mux.
        if (skid_v_q) begin
            instr_o    = skid_instr_q;
            instr_pc_o = skid_pc_q;
        end else if (infl_v_q) begin
            instr_o    = rom_data_i;
            instr_pc_o = infl_pc_q;
        end else begin
            instr_o    = 32'h0;
            instr_pc_o = 32'h0;
        end
        instr_valid_o = (skid_v_q || infl_v_q) && !redirect_i;
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    assign misalign_o = misalign_q;
`else
    assign misalign_o = 1'b0;
    logic unused_misalign;
    assign unused_misalign = misalign_q | redir_misaligned;
`endif

    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_rv32im_fetch_ctrl.sv
// Directed testbench for rv32im_fetch_ctrl. The ROM model answers every read
// with {16'hC0DE, addr[15:0]}, one cycle after the enable. Inputs are driven
// 1 time unit after a rising edge, and outputs are sampled on the falling edge.

module tb_rv32im_fetch_ctrl;

    logic        clk;
    logic        reset_n;
    logic        rom_en_o;
    logic [31:0] rom_addr_o;
    logic [31:0] rom_data_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        misalign_o;
    logic [2:0]  state_dbg_o;

    int n_cmp  = 0;
    int n_fail = 0;

    rv32im_fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .rom_en_o      (rom_en_o),
        .rom_addr_o    (rom_addr_o),
        .rom_data_i    (rom_data_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .misalign_o    (misalign_o),
        .state_dbg_o   (state_dbg_o)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM model: registered read
    initial rom_data_i = 32'h0;
    always @(posedge clk) begin
        if (rom_en_o) rom_data_i <= {16'hC0DE, rom_addr_o[15:0]};
    end

    task automatic drive_pt();
        @(posedge clk);
        #1;
    endtask

    task automatic sample_pt();
        @(negedge clk);
    endtask

    // Reset, release, and stop at the first sample point (S_IDLE cycle).
    task automatic do_reset();
        reset_n       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        instr_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        drive_pt();
        reset_n = 1'b1;
        sample_pt();
    endtask

    task automatic test_reset();
        reset_n       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        instr_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        sample_pt();
        n_cmp++; if (rom_en_o !== 1'b0) begin n_fail++; $display("FAIL reset_rom_en got=%b exp=0", rom_en_o); end
        n_cmp++; if (rom_addr_o !== 32'h0) begin n_fail++; $display("FAIL reset_rom_addr got=%h exp=00000000", rom_addr_o); end
        n_cmp++; if (instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", instr_valid_o); end
        n_cmp++; if (instr_o !== 32'h0) begin n_fail++; $display("FAIL reset_instr got=%h exp=00000000", instr_o); end
        n_cmp++; if (instr_pc_o !== 32'h0) begin n_fail++; $display("FAIL reset_pc got=%h exp=00000000", instr_pc_o); end
        n_cmp++; if (misalign_o !== 1'b0) begin n_fail++; $display("FAIL reset_misalign got=%b exp=0", misalign_o); end
        n_cmp++; if (state_dbg_o !== 3'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", state_dbg_o); end
        drive_pt();
        reset_n = 1'b1;
        sample_pt();
        n_cmp++; if (rom_en_o !== 1'b0) begin n_fail++; $display("FAIL idle_rom_en got=%b exp=0", rom_en_o); end
        n_cmp++; if (instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL idle_valid got=%b exp=0", instr_valid_o); end
    endtask

    // Continues straight from test_reset.
    task automatic test_stream();
        drive_pt(); sample_pt();
        n_cmp++; if (rom_en_o !== 1'b1 || rom_addr_o !== 32'h0) begin n_fail++; $display("FAIL stream_first_issue got en=%b addr=%h exp en=1 addr=00000000", rom_en_o, rom_addr_o); end
        n_cmp++; if (instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL stream_first_valid got=%b exp=0", instr_valid_o); end
        for (int k = 0; k < 6; k++) begin
            logic [31:0] epc;
            epc = 32'(4 * k);
            drive_pt(); sample_pt();
            n_cmp++; if (instr_valid_o !== 1'b1 || instr_pc_o !== epc) begin n_fail++; $display("FAIL stream_pc got v=%b pc=%h exp v=1 pc=%h", instr_valid_o, instr_pc_o, epc); end
            n_cmp++; if (instr_o !== {16'hC0DE, epc[15:0]}) begin n_fail++; $display("FAIL stream_instr got=%h exp=%h", instr_o, {16'hC0DE, epc[15:0]}); end
            n_cmp++; if (rom_en_o !== 1'b1 || rom_addr_o !== epc + 32'd4) begin n_fail++; $display("FAIL stream_issue got en=%b addr=%h exp en=1 addr=%h", rom_en_o, rom_addr_o, epc + 32'd4); end
        end
    endtask

    task automatic test_stall();
        do_reset();
        drive_pt(); sample_pt();           // issue 0
        drive_pt(); sample_pt();           // present 0
        drive_pt(); sample_pt();           // present 4
        for (int k = 0; k < 3; k++) begin  // stall on 8 for three cycles
            drive_pt();
            instr_ready_i = 1'b0;
            sample_pt();
            n_cmp++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h8) begin n_fail++; $display("FAIL stall_hold_pc got v=%b pc=%h exp v=1 pc=00000008", instr_valid_o, instr_pc_o); end
            n_cmp++; if (instr_o !== 32'hC0DE_0008) begin n_fail++; $display("FAIL stall_hold_instr got=%h exp=c0de0008", instr_o); end
            n_cmp++; if (rom_en_o !== 1'b0) begin n_fail++; $display("FAIL stall_rom_en got=%b exp=0", rom_en_o); end
        end
        drive_pt();
        instr_ready_i = 1'b1;
        sample_pt();
        n_cmp++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h8 || instr_o !== 32'hC0DE_0008) begin n_fail++; $display("FAIL stall_accept got v=%b pc=%h i=%h exp v=1 pc=00000008 i=c0de0008", instr_valid_o, instr_pc_o, instr_o); end
        n_cmp++; if (rom_en_o !== 1'b0) begin n_fail++; $display("FAIL stall_accept_rom_en got=%b exp=0", rom_en_o); end
        drive_pt(); sample_pt();
        n_cmp++; if (instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL stall_no_dup got v=%b exp=0", instr_valid_o); end
        n_cmp++; if (rom_en_o !== 1'b1 || rom_addr_o !== 32'hC) begin n_fail++; $display("FAIL stall_reissue got en=%b addr=%h exp en=1 addr=0000000c", rom_en_o, rom_addr_o); end
        drive_pt(); sample_pt();
        n_cmp++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'hC || instr_o !== 32'hC0DE_000C) begin n_fail++; $display("FAIL stall_next12 got v=%b pc=%h i=%h exp v=1 pc=0000000c i=c0de000c", instr_valid_o, instr_pc_o, instr_o); end
        drive_pt(); sample_pt();
        n_cmp++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h10) begin n_fail++; $display("FAIL stall_next16 got v=%b pc=%h exp v=1 pc=00000010", instr_valid_o, instr_pc_o); end
    endtask

    task automatic test_redirect_skid();
        do_reset();
        drive_pt(); sample_pt();           // issue 0
        for (int k = 0; k < 4; k++) begin  // present 0,4,8,C
            drive_pt(); sample_pt();
        end
        drive_pt();
        instr_ready_i = 1'b0;              // 0x10 refused -> skid
        sample_pt();
        n_cmp++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h10) begin n_fail++; $display("FAIL redir_pre got v=%b pc=%h exp v=1 pc=00000010", instr_valid_o, instr_pc_o); end
        drive_pt();
        instr_ready_i = 1'b1;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h40;
        sample_pt();
        n_cmp++; if (instr_valid_o !== 1'b0 || rom_en_o !== 1'b0) begin n_fail++; $display("FAIL redir_cycle got v=%b en=%b exp v=0 en=0", instr_valid_o, rom_en_o); end
        drive_pt();
        redirect_i = 1'b0;
        sample_pt();
        n_cmp++; if (instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL redir_gap got v=%b exp=0", instr_valid_o); end
        n_cmp++; if (rom_en_o !== 1'b1 || rom_addr_o !== 32'h40) begin n_fail++; $display("FAIL redir_issue got en=%b addr=%h exp en=1 addr=00000040", rom_en_o, rom_addr_o); end
        drive_pt(); sample_pt();
        n_cmp++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h40 || instr_o !== 32'hC0DE_0040) begin n_fail++; $display("FAIL redir_target got v=%b pc=%h i=%h exp v=1 pc=00000040 i=c0de0040", instr_valid_o, instr_pc_o, instr_o); end
        drive_pt(); sample_pt();
        n_cmp++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h44) begin n_fail++; $display("FAIL redir_next got v=%b pc=%h exp v=1 pc=00000044", instr_valid_o, instr_pc_o); end
    endtask

    // Continues straight from test_redirect_skid.
    task automatic test_wrap();
        drive_pt();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFF8;
        sample_pt();
        n_cmp++; if (instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL wrap_redir_valid got=%b exp=0", instr_valid_o); end
        drive_pt();
        redirect_i = 1'b0;
        sample_pt();
        n_cmp++; if (rom_en_o !== 1'b1 || rom_addr_o !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL wrap_issue got en=%b addr=%h exp en=1 addr=fffffff8", rom_en_o, rom_addr_o); end
        drive_pt(); sample_pt();
        n_cmp++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'hFFFF_FFF8 || instr_o !== 32'hC0DE_FFF8) begin n_fail++; $display("FAIL wrap_pc0 got v=%b pc=%h i=%h exp v=1 pc=fffffff8 i=c0defff8", instr_valid_o, instr_pc_o, instr_o); end
        drive_pt(); sample_pt();
        n_cmp++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'hFFFF_FFFC || instr_o !== 32'hC0DE_FFFC) begin n_fail++; $display("FAIL wrap_pc1 got v=%b pc=%h i=%h exp v=1 pc=fffffffc i=c0defffc", instr_valid_o, instr_pc_o, instr_o); end
        drive_pt(); sample_pt();
        n_cmp++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h0 || instr_o !== 32'hC0DE_0000) begin n_fail++; $display("FAIL wrap_pc2 got v=%b pc=%h i=%h exp v=1 pc=00000000 i=c0de0000", instr_valid_o, instr_pc_o, instr_o); end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive_pt(); sample_pt();           // issue 0
        for (int k = 0; k < 9; k++) begin  // present 0 .. 0x20
            drive_pt(); sample_pt();
        end
        n_cmp++; if (instr_pc_o !== 32'h20) begin n_fail++; $display("FAIL areset_pre got pc=%h exp=00000020", instr_pc_o); end
        drive_pt();
        reset_n = 1'b0;
        #2;
        n_cmp++; if (rom_en_o !== 1'b0 || rom_addr_o !== 32'h0) begin n_fail++; $display("FAIL areset_rom got en=%b addr=%h exp en=0 addr=00000000", rom_en_o, rom_addr_o); end
        n_cmp++; if (instr_valid_o !== 1'b0 || instr_o !== 32'h0 || instr_pc_o !== 32'h0) begin n_fail++; $display("FAIL areset_out got v=%b i=%h pc=%h exp v=0 i=0 pc=0", instr_valid_o, instr_o, instr_pc_o); end
        drive_pt();
        reset_n = 1'b1;
        sample_pt();
        n_cmp++; if (rom_en_o !== 1'b0 || instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL areset_idle got en=%b v=%b exp en=0 v=0", rom_en_o, instr_valid_o); end
        drive_pt(); sample_pt();
        n_cmp++; if (rom_en_o !== 1'b1 || rom_addr_o !== 32'h0) begin n_fail++; $display("FAIL areset_issue got en=%b addr=%h exp en=1 addr=00000000", rom_en_o, rom_addr_o); end
        drive_pt(); sample_pt();
        n_cmp++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h0 || instr_o !== 32'hC0DE_0000) begin n_fail++; $display("FAIL areset_restart got v=%b pc=%h i=%h exp v=1 pc=00000000 i=c0de0000", instr_valid_o, instr_pc_o, instr_o); end
    endtask

    task automatic test_misalign();
        do_reset();
        drive_pt(); sample_pt();           // issue 0
        drive_pt(); sample_pt();           // present 0
        drive_pt();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h42;
        sample_pt();
        n_cmp++; if (instr_valid_o !== 1'b0 || rom_en_o !== 1'b0) begin n_fail++; $display("FAIL mis_redir_cycle got v=%b en=%b exp v=0 en=0", instr_valid_o, rom_en_o); end
        drive_pt();
        redirect_i = 1'b0;
        sample_pt();
`ifdef FETCH_MISALIGN_TRAP_EN
        for (int k = 0; k < 2; k++) begin
            n_cmp++; if (misalign_o !== 1'b1 || rom_en_o !== 1'b0 || instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL mis_trap got m=%b en=%b v=%b exp m=1 en=0 v=0", misalign_o, rom_en_o, instr_valid_o); end
            drive_pt(); sample_pt();
        end
        drive_pt();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h40;
        sample_pt();
        n_cmp++; if (misalign_o !== 1'b1 || instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL mis_exit_cycle got m=%b v=%b exp m=1 v=0", misalign_o, instr_valid_o); end
        drive_pt();
        redirect_i = 1'b0;
        sample_pt();
        n_cmp++; if (misalign_o !== 1'b0 || rom_en_o !== 1'b1 || rom_addr_o !== 32'h40) begin n_fail++; $display("FAIL mis_exit_issue got m=%b en=%b addr=%h exp m=0 en=1 addr=00000040", misalign_o, rom_en_o, rom_addr_o); end
`else
        n_cmp++; if (misalign_o !== 1'b0 || rom_en_o !== 1'b1 || rom_addr_o !== 32'h40) begin n_fail++; $display("FAIL mis_align_issue got m=%b en=%b addr=%h exp m=0 en=1 addr=00000040", misalign_o, rom_en_o, rom_addr_o); end
`endif
        drive_pt(); sample_pt();
        n_cmp++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h40 || instr_o !== 32'hC0DE_0040 || misalign_o !== 1'b0) begin n_fail++; $display("FAIL mis_target got v=%b pc=%h i=%h m=%b exp v=1 pc=00000040 i=c0de0040 m=0", instr_valid_o, instr_pc_o, instr_o, misalign_o); end
    endtask

    initial begin
        reset_n       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        instr_ready_i = 1'b1;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_skid();
        test_wrap();
        test_async_reset();
        test_misalign();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
